uart_boot_loader: RTL and testbench

//  Bus initiator fed by the UART receive path: takes received bytes (uart_rx dout /
//  rx_done_tick), parses a framed program image and writes it word-by-word into

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_boot_loader.sv | 200 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame-format constants for the UART boot loader.
// The frame is SYNC, LEN_LO, LEN_HI, then 4*N data bytes (LSB first), then CSUM.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StError
    } loader_state_t;

    localparam logic [7:0]  DefaultSyncByte = 8'hA5;
    localparam int unsigned BytesPerWord    = 4;
    localparam int unsigned WordCountW      = 16;

    // Byte address of a word index; indices are word-granular, so scale by 4.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [WordCountW-1:0] idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/uart_boot_loader.sv
// Parses a framed program image arriving as UART bytes and writes it word-by-word
// into memory, holding the core in reset until an image is accepted.
module uart_boot_loader
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter logic [7:0]  SYNC_BYTE      = DefaultSyncByte,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter bit          BOOT_HOLD      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_reset,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned   GapW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GapW-1:0] GapLimit = GapW'(TIMEOUT_CYCLES - 1);

    loader_state_t         state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [WordCountW-1:0] len_q, len_d;
    logic [WordCountW-1:0] word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  in_frame;
    logic                  timeout;
    logic                  is_sync;
    logic                  last_byte;
    logic                  last_word;
    logic [WordCountW-1:0] len_rx;

    assign in_frame  = (state_q == StLen0) || (state_q == StLen1) ||
                       (state_q == StData) || (state_q == StCsum);
    // A byte arriving in the limit cycle takes priority over the timeout.
    assign timeout   = in_frame && !rx_valid && (gap_q == GapLimit);
    assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
    assign last_byte = (byte_idx_q == 2'd3);
    assign last_word = (word_idx_q == len_q - 16'd1);
    assign len_rx    = {rx_data, len_lo_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            len_lo_q    <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            gap_q       <= '0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_reset_q <= BOOT_HOLD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            gap_q       <= gap_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (is_sync) state_d = StLen0;
            end
            StLen0: begin
                if (rx_valid) state_d = StLen1;
            end
            StLen1: begin
                if (rx_valid) begin
                    if (32'(len_rx) > MAX_WORDS) state_d = StError;
                    else if (len_rx == '0)       state_d = StCsum;
                    else                         state_d = StData;
                end
            end
            StData: begin
                if (rx_valid && last_byte && last_word) state_d = StCsum;
            end
            StCsum: begin
                if (rx_valid) state_d = (rx_data == csum_q) ? StDone : StError;
            end
            default: state_d = StIdle;
        endcase
        if (timeout) state_d = StError;
    end

    always_comb begin
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        csum_d      = csum_q;
        gap_d       = (in_frame && !rx_valid) ? gap_q + 1'b1 : '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (is_sync) begin
                    cpu_reset_d = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    word_idx_d  = '0;
                    byte_idx_d  = '0;
                    csum_d      = '0;
                end
            end
            StLen0: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    csum_d   = csum_q ^ rx_data;
                end
            end
            StLen1: begin
                if (rx_valid) begin
                    len_d  = len_rx;
                    csum_d = csum_q ^ rx_data;
                end
            end
            StData: begin
                if (rx_valid) begin
                    csum_d                     = csum_q ^ rx_data;
                    word_d[8*byte_idx_q +: 8]  = rx_data;
                    byte_idx_d                 = byte_idx_q + 2'd1;
                    if (last_byte) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_addr(BASE_ADDR, word_idx_q);
                        mem_wdata_d = word_d;
                        word_idx_d  = word_idx_q + 16'd1;
                    end
                end
            end
            default: ;
        endcase

        if (state_q == StCsum && state_d == StDone) begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
            busy_d      = 1'b0;
        end
        // Already-written words are left in memory; only the flags report the failure.
        if (in_frame && state_d == StError) begin
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
            busy_d      = 1'b0;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_error = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected memory writes are queued as frames
// are built and popped as the DUT strobes mem_we.
module tb_uart_boot_loader;

    localparam logic [31:0] BaseAddr      = 32'h0000_0000;
    localparam int unsigned MaxWords      = 1024;
    localparam int unsigned TimeoutCycles = 200;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        cpu_reset;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    int          checks   = 0;
    int          failures = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic        prev_we  = 1'b0;
    logic [7:0]  frame[$];
    logic [31:0] words[$];

    uart_boot_loader #(
        .BASE_ADDR     (BaseAddr),
        .MAX_WORDS     (MaxWords),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TimeoutCycles),
        .BOOT_HOLD     (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_reset (cpu_reset),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            check("we_back_to_back", {31'b0, prev_we}, 32'd0);
            check("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", mem_addr, mon_e.addr);
                check("wr_data", mem_wdata, mon_e.data);
            end
        end
        prev_we = mem_we;
    end

    // gap = idle cycles after this byte; gap 0 leaves rx_valid high for the next byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (gap > 0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic end_bytes();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic make_frame(input bit corrupt);
        logic [7:0]  csum;
        logic [15:0] n;
        logic [31:0] w;
        n     = 16'(words.size());
        frame = {};
        frame.push_back(8'hA5);
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        csum = n[7:0] ^ n[15:8];
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                frame.push_back(w[8*b +: 8]);
                csum ^= w[8*b +: 8];
            end
            exp_q.push_back('{addr: BaseAddr + 32'(4 * i), data: w});
        end
        frame.push_back(corrupt ? ~csum : csum);
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < frame.size(); i++) send_byte(frame[i], gap);
        end_bytes();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50 && load_busy; i++) @(negedge clk);
        check(tag, {31'b0, load_busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err,
                               input logic cpu_rst);
        check({tag, "_done"}, {31'b0, load_done}, {31'b0, done});
        check({tag, "_error"}, {31'b0, load_error}, {31'b0, err});
        check({tag, "_cpu_reset"}, {31'b0, cpu_reset}, {31'b0, cpu_rst});
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, mem_addr, BaseAddr);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_busy"}, {31'b0, load_busy}, 32'd0);
        check({tag, "_done"}, {31'b0, load_done}, 32'd0);
        check({tag, "_error"}, {31'b0, load_error}, 32'd0);
        check({tag, "_cpu_reset"}, {31'b0, cpu_reset}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("rst");

        // 1: literal two-word image, csum 0x02^0x88
        frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
        exp_q.push_back('{addr: 32'h4, data: 32'h8877_6655});
        send_frame(2);
        wait_idle("t1_idle");
        check_flags("t1", 1'b1, 1'b0, 1'b0);

        // 2: same image, bad csum; writes still happen
        frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h8B};
        exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
        exp_q.push_back('{addr: 32'h4, data: 32'h8877_6655});
        send_frame(1);
        wait_idle("t2_idle");
        check_flags("t2", 1'b0, 1'b1, 1'b1);

        // 3: empty image
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(3);
        wait_idle("t3_idle");
        check_flags("t3", 1'b1, 1'b0, 1'b0);

        // back-to-back bytes, including one in the cycle after a write strobe
        words = '{32'hDEAD_BEEF, 32'h0102_0304, 32'hCAFE_F00D};
        make_frame(1'b0);
        send_frame(0);
        wait_idle("b2b_idle");
        check_flags("b2b", 1'b1, 1'b0, 1'b0);

        // 4: oversize length; trailing bytes must not write
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h04, 3);
        check_flags("t4", 1'b0, 1'b1, 1'b1);
        check("t4_busy", {31'b0, load_busy}, 32'd0);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h44, 3);
        check_flags("t4_after", 1'b0, 1'b1, 1'b1);

        // 5: stall after the second data byte
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 0);
        end_bytes();
        repeat (TimeoutCycles - 10) @(negedge clk);
        check("t5_pre_timeout_error", {31'b0, load_error}, 32'd0);
        check("t5_pre_timeout_busy", {31'b0, load_busy}, 32'd1);
        repeat (20) @(negedge clk);
        check_flags("t5", 1'b0, 1'b1, 1'b1);
        check("t5_busy", {31'b0, load_busy}, 32'd0);
        words = '{$urandom, $urandom, $urandom, $urandom};
        make_frame(1'b0);
        send_frame(2);
        wait_idle("t5_idle");
        check_flags("t5_recover", 1'b1, 1'b0, 1'b0);

        // 6: reset in the middle of DATA after one word was written
        send_byte(8'hA5, 1);
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h44, 2);
        send_byte(8'h55, 1);
        send_byte(8'h66, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("t6_rst");
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        words = '{32'hA5A5_A5A5, 32'h00A5_11A5};
        make_frame(1'b0);
        send_frame(1);
        wait_idle("t6_idle");
        check_flags("t6", 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
